// File: rtl/bus_wait_ctrl_if.sv
// CPU-side bus signals of the V810 external bus as seen by the wait-state
// controller. The CPU (or a bench standing in for it) uses the master view;
// the controller uses the slave view.
interface bus_wait_ctrl_if;
    logic [31:0] CTLR_A;       // CPU address, A[26:24] selects the region
    logic        CTLR_BCYSTn;  // bus cycle start strobe (T1), active low
    logic        CTLR_DAn;     // data strobe (T2 onwards), active low
    logic        CTLR_READYn;  // cycle complete, active low
    logic        CTLR_SZRQn;   // 16-bit size request, active low

    modport master (
        output CTLR_A,
        output CTLR_BCYSTn,
        output CTLR_DAn,
        input  CTLR_READYn,
        input  CTLR_SZRQn
    );

    modport slave (
        input  CTLR_A,
        input  CTLR_BCYSTn,
        input  CTLR_DAn,
        output CTLR_READYn,
        output CTLR_SZRQn
    );
endinterface

// File: rtl/bus_wait_ctrl.sv
// Address-decoded bus cycle controller for the V810 external bus.
// Each bus cycle is decoded into one of 8 regions by A[26:24]; the region's
// chip enable is driven low, its programmed wait states are inserted once the
// data strobe is seen, and the CPU is answered with READYn / SZRQn.
// Region configuration is sampled only at cycle start, so reprogramming in the
// middle of a cycle takes effect from the next cycle.
module bus_wait_ctrl (
    input  logic                  CLK,
    input  logic                  RESET,    // synchronous, active high
    input  logic                  CE,       // clock enable for all state
    bus_wait_ctrl_if.slave        bus,
    input  logic [7:0]            CFG_EN,   // 0 = region unmapped
    input  logic [15:0]           CFG_WS,   // 2 wait-state bits per region
    input  logic [7:0]            CFG_W16,  // 1 = 16-bit region
    output logic [7:0]            MEM_nCE,
    output logic                  BUSERR
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      state_q;
    logic [2:0]  rgn_q;
    logic [1:0]  cnt_q;
    logic        w16_q;
    logic        en_q;
    logic [7:0]  nce_q;

    logic [2:0]  rgn_d;
    logic [1:0]  cnt_d;
    logic        w16_d;
    logic        en_d;
    logic [7:0]  nce_d;
    logic        ready;

    // Only A[26:24] take part in decoding; the rest of the address is ignored.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.CTLR_A[31:27], bus.CTLR_A[23:0]};

    // Per-region values that would be latched if a cycle starts this clock.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rgn_d        = bus.CTLR_A[26:24];
        cnt_d        = CFG_WS[{rgn_d, 1'b0} +: 2];
        w16_d        = CFG_W16[rgn_d];
        en_d         = CFG_EN[rgn_d];
        nce_d        = 8'hFF;
        if (en_d) begin
            nce_d[rgn_d] = 1'b0;
        end
    end

    // Cycle completes once the data strobe is low and all waits have elapsed;
    // deliberately combinational on DAn so READYn can fall in T2 with no waits.
    always_comb begin
        ready = (state_q == ACTIVE) && !bus.CTLR_DAn && (cnt_q == 2'd0);
    end

    assign bus.CTLR_READYn = ~ready;
    assign bus.CTLR_SZRQn  = ~(ready & w16_q & en_q);
    assign BUSERR          = ready & ~en_q;
    assign MEM_nCE         = nce_q;

    // Cycle FSM: launch on BCYSTn (also from ACTIVE for back-to-back cycles),
    // count waits only while DAn is low, return to IDLE on completion.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RESET) begin
                state_q <= IDLE;
                rgn_q   <= 3'd0;
                cnt_q   <= 2'd0;
                w16_q   <= 1'b0;
                en_q    <= 1'b0;
                nce_q   <= 8'hFF;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.CTLR_BCYSTn) begin
                            state_q <= ACTIVE;
                            rgn_q   <= rgn_d;
                            cnt_q   <= cnt_d;
                            w16_q   <= w16_d;
                            en_q    <= en_d;
                            nce_q   <= nce_d;
                        end
                    end
                    ACTIVE: begin
                        if (!bus.CTLR_BCYSTn) begin
                            // A new start strobe abandons the current cycle.
                            state_q <= ACTIVE;
                            rgn_q   <= rgn_d;
                            cnt_q   <= cnt_d;
                            w16_q   <= w16_d;
                            en_q    <= en_d;
                            nce_q   <= nce_d;
                        end else if (ready) begin
                            state_q <= IDLE;
                            nce_q   <= 8'hFF;
                        end else if (!bus.CTLR_DAn && (cnt_q != 2'd0)) begin
                            cnt_q   <= cnt_q - 2'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        nce_q   <= 8'hFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Self-checking bench for bus_wait_ctrl: a table of directed cycles, a few
// hand-written multi-cycle sequences, then randomized traffic compared with a
// transaction-level reference model.
module tb_bus_wait_ctrl;

    logic        CLK;
    logic        RESET;
    logic        CE;
    logic [7:0]  cfg_en;
    logic [15:0] cfg_ws;
    logic [7:0]  cfg_w16;
    logic [7:0]  mem_nce;
    logic        buserr;

    int checks   = 0;
    int failures = 0;

    bus_wait_ctrl_if bus ();

    bus_wait_ctrl dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .CE      (CE),
        .bus     (bus),
        .CFG_EN  (cfg_en),
        .CFG_WS  (cfg_ws),
        .CFG_W16 (cfg_w16),
        .MEM_nCE (mem_nce),
        .BUSERR  (buserr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       ce;
        logic       bc_n;
        logic       da_n;
        logic [2:0] rgn;
        logic       rdy_n;
        logic       sz_n;
        logic [7:0] nce;
        logic       berr;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one clock of inputs (called just after a rising edge), compare the
    // outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic ce, input logic rst,
                       input logic bc_n, input logic da_n, input logic [2:0] rgn,
                       input logic rdy_n, input logic sz_n, input logic [7:0] nce,
                       input logic berr);
        logic [31:0] a;
        a         = $urandom;
        a[26:24]  = rgn;
        CE              = ce;
        RESET           = rst;
        bus.CTLR_BCYSTn = bc_n;
        bus.CTLR_DAn    = da_n;
        bus.CTLR_A      = a;
        #2;
        check({name, ".READYn"}, {31'd0, bus.CTLR_READYn}, {31'd0, rdy_n});
        check({name, ".SZRQn"},  {31'd0, bus.CTLR_SZRQn},  {31'd0, sz_n});
        check({name, ".nCE"},    {24'd0, mem_nce},         {24'd0, nce});
        check({name, ".BUSERR"}, {31'd0, buserr},          {31'd0, berr});
        @(posedge CLK);
        #1;
    endtask

    // Transaction-level reference: an access is open or not; it finishes when
    // the number of strobed wait cycles reaches the programmed count.
    typedef struct {
        bit busy;
        int rgn;
        int ws;
        bit w16;
        bit en;
        int waited;
    } acc_t;

    acc_t m;

    task automatic rstep(input logic ce, input logic rst, input logic bc_n,
                         input logic da_n, input logic [31:0] a);
        bit         rdy;
        logic [7:0] exp_nce;
        int         r;
        CE              = ce;
        RESET           = rst;
        bus.CTLR_BCYSTn = bc_n;
        bus.CTLR_DAn    = da_n;
        bus.CTLR_A      = a;
        #2;
        rdy     = m.busy && !da_n && (m.waited >= m.ws);
        exp_nce = 8'hFF;
        if (m.busy && m.en) exp_nce[m.rgn] = 1'b0;
        check("rnd.READYn", {31'd0, bus.CTLR_READYn}, {31'd0, !rdy});
        check("rnd.SZRQn",  {31'd0, bus.CTLR_SZRQn},  {31'd0, !(rdy && m.w16 && m.en)});
        check("rnd.nCE",    {24'd0, mem_nce},         {24'd0, exp_nce});
        check("rnd.BUSERR", {31'd0, buserr},          {31'd0, rdy && !m.en});
        if (ce) begin
            if (rst) begin
                m.busy = 0;
            end else if (!bc_n) begin
                r        = int'(a[26:24]);
                m.busy   = 1;
                m.rgn    = r;
                m.ws     = int'((cfg_ws >> (2 * r)) & 16'h3);
                m.w16    = cfg_w16[r];
                m.en     = cfg_en[r];
                m.waited = 0;
            end else if (rdy) begin
                m.busy = 0;
            end else if (m.busy && !da_n) begin
                m.waited++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // r7 WS0, r5 WS3, r2 WS2, r1 WS2, r0 WS1; r2 unmapped; r0 16-bit
        cfg_en          = 8'hFB;
        cfg_ws          = 16'h0C29;
        cfg_w16         = 8'h01;
        CE              = 1'b1;
        RESET           = 1'b1;
        bus.CTLR_BCYSTn = 1'b1;
        bus.CTLR_DAn    = 1'b1;
        bus.CTLR_A      = 32'd0;

        //          ce    bc_n  da_n  rgn   rdy_n sz_n  nce    berr
        // 1: region 7, no waits
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h7F, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};
        // 2: region 5, 3 waits, CE low for 2 clocks in T3
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'hDF, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};
        // 4: unmapped region 2, 2 waits, bus error on completion
        tbl[12] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'hFF, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};
        // region 1, 2 waits, wait count holds while DAn is high
        tbl[17] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFD, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFD, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFD, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFD, 1'b0};
        tbl[22] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'hFD, 1'b0};
        tbl[23] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0};

        @(posedge CLK);
        #1;
        cyc("reset0", 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("reset1", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);

        for (int i = 0; i < 24; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].ce, 1'b0, tbl[i].bc_n, tbl[i].da_n,
                tbl[i].rgn, tbl[i].rdy_n, tbl[i].sz_n, tbl[i].nce, tbl[i].berr);
        end

        // 3: 16-bit region 0 with 1 wait, upper half rerun as a new cycle
        cyc("w16.t1",  1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("w16.t2",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFE, 1'b0);
        cyc("w16.t3",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFE, 1'b0);
        cyc("w16.t1b", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("w16.t2b", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFE, 1'b0);
        cyc("w16.t3b", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFE, 1'b0);
        cyc("w16.end", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);

        // 5: start in the ready cycle of region 7 relaunches to region 1;
        // region 1 wait count reprogrammed mid-cycle takes effect next cycle
        cyc("b2b.t1",  1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("b2b.rdy", 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h7F, 1'b0);
        cfg_ws = 16'h0C21;
        cyc("b2b.w2",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFD, 1'b0);
        cyc("b2b.w1",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFD, 1'b0);
        cyc("b2b.w0",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'hFD, 1'b0);
        cyc("b2b.idl", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("new.t1",  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("new.t2",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'hFD, 1'b0);
        cyc("new.end", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
        cfg_ws = 16'h0C29;

        // 6: reset while region 5 still has 2 waits to go
        cyc("rst.t1",  1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("rst.t2",  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0);
        cyc("rst.hit", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hDF, 1'b0);
        cyc("rst.aft", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("rst.t1b", 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("rst.t2b", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h7F, 1'b0);
        cyc("rst.t3b", 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);

        // Randomized traffic against the reference model, from a clean reset.
        m = '{busy: 0, rgn: 0, ws: 0, w16: 0, en: 0, waited: 0};
        rstep(1'b1, 1'b1, 1'b1, 1'b1, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            logic rst_r;
            logic ce_r;
            if ($urandom_range(0, 49) == 0) begin
                cfg_en  = 8'($urandom);
                cfg_ws  = 16'($urandom);
                cfg_w16 = 8'($urandom);
            end
            rst_r = ($urandom_range(0, 99) == 0);
            ce_r  = rst_r ? 1'b1 : ($urandom_range(0, 4) != 0);
            rstep(ce_r, rst_r, ($urandom_range(0, 5) != 0), 1'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
